// File: rtl/xrv_mem_arb.sv
// -----------------------------------------------------------------------------
// xrv_mem_arb
//   Shares one memory bus between the instruction-fetch (IF) port and the
//   load/store (LS) port. LS normally wins because it stalls the pipeline.
//   A starvation counter forces IF through after STARVE_MAX consecutive LS
//   wins. Only one transaction is outstanding at a time, and its response is
//   routed back to the port that owns it. A flush kills an in-flight fetch
//   response so no stale instruction reaches IF.
//
// Ports
//   clk, rstb                 clock, asynchronous active-low reset
//   flush                     pipeline flush, kills the in-flight fetch
//   if_req/if_addr            fetch request (level) and address
//   if_gnt/if_rvalid/if_rdata fetch accept, response valid, response data
//   ls_req/ls_we/ls_be/
//   ls_addr/ls_wdata          load/store request (level) and payload
//   ls_gnt/ls_rvalid/ls_rdata LS accept, completion, load data
//   mem_req/mem_we/mem_be/
//   mem_addr/mem_wdata        memory bus request, muxed from the winner
//   mem_gnt/mem_rvalid/
//   mem_rdata                 memory bus accept and response
//   busy                      a transaction is outstanding or being dropped
// -----------------------------------------------------------------------------
module xrv_mem_arb #(
  parameter int AW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          flush,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [3:0]    ls_be,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [31:0]   ls_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2,
    ST_DROP    = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_starve_cnt;

  logic w_idle;
  logic w_starved;
  logic w_sel_if;
  logic w_sel_ls;

  // Arbitration is purely combinational and re-evaluated every idle cycle;
  // nothing is locked until the memory grants, so the winner may change
  // while mem_gnt is still low.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_idle    = (r_state == ST_IDLE);
    w_starved = (r_starve_cnt == CW'(STARVE_MAX));
    // A flush blocks the fetch grant in the same cycle; LS is unaffected.
    w_sel_if  = w_idle & if_req & ~flush & (~ls_req | w_starved);
    w_sel_ls  = w_idle & ls_req & ~w_sel_if;

    mem_req   = w_sel_if | w_sel_ls;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (w_sel_if) begin
      mem_be   = 4'hF;
      mem_addr = if_addr;
    end else if (w_sel_ls) begin
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end

    if_gnt = mem_gnt & w_sel_if;
    ls_gnt = mem_gnt & w_sel_ls;

    // Responses are routed in the same cycle they arrive. A flush coincident
    // with the fetch response suppresses it.
    if_rvalid = (r_state == ST_BUSY_IF) & mem_rvalid & ~flush;
    ls_rvalid = (r_state == ST_BUSY_LS) & mem_rvalid;
    if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    ls_rdata  = ls_rvalid ? mem_rdata : 32'h0;

    busy = ~w_idle;
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (if_gnt)      r_state <= ST_BUSY_IF;
          else if (ls_gnt) r_state <= ST_BUSY_LS;
        end
        ST_BUSY_IF: begin
          if (mem_rvalid) r_state <= ST_IDLE;
          else if (flush) r_state <= ST_DROP;
        end
        ST_BUSY_LS: begin
          if (mem_rvalid) r_state <= ST_IDLE;
        end
        ST_DROP: begin
          // The dropped fetch response is swallowed; further flushes are moot.
          if (mem_rvalid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Counts LS wins taken while IF was waiting; an IF grant clears it.
      if (if_gnt)
        r_starve_cnt <= '0;
      else if (ls_gnt && if_req && !w_starved)
        r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_xrv_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_xrv_mem_arb
//   Directed bench for xrv_mem_arb. Inputs change 1 time unit after the rising
//   edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_xrv_mem_arb;

  localparam int AW = 32;

  logic          clk;
  logic          rstb;
  logic          flush;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [3:0]    ls_be;
  logic [AW-1:0] ls_addr;
  logic [31:0]   ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [31:0]   ls_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  xrv_mem_arb #(.AW(AW), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .flush      (flush),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_be      (ls_be),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's drive point.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    flush      = 1'b0;
    if_req     = 1'b0;
    if_addr    = '0;
    ls_req     = 1'b0;
    ls_we      = 1'b0;
    ls_be      = 4'h0;
    ls_addr    = '0;
    ls_wdata   = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // With all inputs low every output must be 0.
  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},   {31'h0, mem_req},   32'h0);
    check({tag, "_gnts"},      {30'h0, if_gnt, ls_gnt}, 32'h0);
    check({tag, "_rvalids"},   {30'h0, if_rvalid, ls_rvalid}, 32'h0);
    check({tag, "_if_rdata"},  if_rdata,  32'h0);
    check({tag, "_ls_rdata"},  ls_rdata,  32'h0);
    check({tag, "_mem_addr"},  mem_addr,  32'h0);
    check({tag, "_mem_misc"},  {27'h0, mem_we, mem_be}, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_busy"},      {31'h0, busy}, 32'h0);
  endtask

  // Expected T2 grant order: 1 = IF, 0 = LS.
  logic exp_if_win [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    clear_inputs();
    rstb = 1'b0;
    repeat (2) @(posedge clk);
    sample();
    check_all_zero("reset");
    next_cycle();
    rstb = 1'b1;

    // ---------------- T1: single load ----------------
    ls_req = 1'b1; ls_addr = 32'h100; ls_be = 4'hF; mem_gnt = 1'b1;
    sample();
    check("t1_mem_req",  {31'h0, mem_req}, 32'h1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_ls_gnt",   {31'h0, ls_gnt}, 32'h1);
    check("t1_if_gnt",   {31'h0, if_gnt}, 32'h0);
    next_cycle();
    ls_req = 1'b0; mem_gnt = 1'b0;
    sample();
    check("t1_busy",        {31'h0, busy}, 32'h1);
    check("t1_gnt_pulse",   {31'h0, ls_gnt}, 32'h0);
    check("t1_busy_no_req", {31'h0, mem_req}, 32'h0);
    check("t1_no_early_rv", {31'h0, ls_rvalid}, 32'h0);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    sample();
    check("t1_ls_rvalid", {31'h0, ls_rvalid}, 32'h1);
    check("t1_ls_rdata",  ls_rdata, 32'hDEADBEEF);
    check("t1_if_rvalid", {31'h0, if_rvalid}, 32'h0);
    check("t1_if_rdata",  if_rdata, 32'h0);
    next_cycle();
    // Spurious response in IDLE must be ignored.
    mem_rdata = 32'h55AA55AA;
    sample();
    check("spur_rvalids", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
    check("spur_ls_rdata", ls_rdata, 32'h0);
    check("spur_busy",    {31'h0, busy}, 32'h0);
    next_cycle();
    clear_inputs();

    // ---------------- T2: starvation ----------------
    if_req = 1'b1; if_addr = 32'h400; ls_req = 1'b1; ls_addr = 32'h500;
    ls_be = 4'hF; mem_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_rvalid = 1'b0;
      sample();
      check($sformatf("t2_if_gnt_%0d", i), {31'h0, if_gnt}, {31'h0, exp_if_win[i]});
      check($sformatf("t2_ls_gnt_%0d", i), {31'h0, ls_gnt}, {31'h0, ~exp_if_win[i]});
      check($sformatf("t2_addr_%0d", i), mem_addr, exp_if_win[i] ? 32'h400 : 32'h500);
      next_cycle();
      mem_rvalid = 1'b1; mem_rdata = 32'hA000 + i;
      sample();
      if (exp_if_win[i])
        check($sformatf("t2_if_rdata_%0d", i), if_rdata, 32'hA000 + i);
      else
        check($sformatf("t2_ls_rdata_%0d", i), ls_rdata, 32'hA000 + i);
      next_cycle();
    end
    clear_inputs();

    // ---------------- T3: flush before response -> DROP ----------------
    if_req = 1'b1; if_addr = 32'h200; mem_gnt = 1'b1;
    sample();
    check("t3_if_gnt",    {31'h0, if_gnt}, 32'h1);
    check("t3_mem_addr",  mem_addr, 32'h200);
    check("t3_mem_be",    {28'h0, mem_be}, 32'hF);
    check("t3_mem_wdata", mem_wdata, 32'h0);
    next_cycle();
    if_req = 1'b0; mem_gnt = 1'b0; flush = 1'b1;
    sample();
    check("t3_busy_if", {31'h0, busy}, 32'h1);
    next_cycle();
    // In DROP: a second flush has no effect.
    sample();
    check("t3_drop_busy", {31'h0, busy}, 32'h1);
    check("t3_drop_rv",   {31'h0, if_rvalid}, 32'h0);
    next_cycle();
    flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    sample();
    check("t3_drop_rv2",   {31'h0, if_rvalid}, 32'h0);
    check("t3_drop_rdata", if_rdata, 32'h0);
    check("t3_drop_busy2", {31'h0, busy}, 32'h1);
    next_cycle();
    mem_rvalid = 1'b0;
    sample();
    check("t3_idle", {31'h0, busy}, 32'h0);

    // Flush in IDLE blocks the fetch grant.
    if_req = 1'b1; mem_gnt = 1'b1; flush = 1'b1;
    sample();
    check("idle_flush_if_gnt", {31'h0, if_gnt}, 32'h0);
    check("idle_flush_req",    {31'h0, mem_req}, 32'h0);
    next_cycle();
    sample();
    check("idle_flush_busy", {31'h0, busy}, 32'h0);
    next_cycle();
    flush = 1'b0;

    // ---------------- T4: flush coincident with response ----------------
    sample();
    check("t4_if_gnt", {31'h0, if_gnt}, 32'h1);
    next_cycle();
    if_req = 1'b0; mem_gnt = 1'b0; flush = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
    sample();
    check("t4_if_rvalid", {31'h0, if_rvalid}, 32'h0);
    check("t4_if_rdata",  if_rdata, 32'h0);
    next_cycle();
    clear_inputs();
    sample();
    check("t4_idle", {31'h0, busy}, 32'h0);
    next_cycle();

    // ---------------- T5: store, flush in BUSY_LS ----------------
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_wdata = 32'h1234;
    ls_addr = 32'h300; mem_gnt = 1'b1;
    sample();
    check("t5_ls_gnt",    {31'h0, ls_gnt}, 32'h1);
    check("t5_mem_we",    {31'h0, mem_we}, 32'h1);
    check("t5_mem_be",    {28'h0, mem_be}, 32'h3);
    check("t5_mem_wdata", mem_wdata, 32'h1234);
    next_cycle();
    ls_req = 1'b0; mem_gnt = 1'b0; flush = 1'b1;
    sample();
    check("t5_flush_busy", {31'h0, busy}, 32'h1);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    sample();
    check("t5_ack", {31'h0, ls_rvalid}, 32'h1);
    next_cycle();
    clear_inputs();
    sample();
    check("t5_idle", {31'h0, busy}, 32'h0);
    next_cycle();

    // ---------------- T6: reset during BUSY_LS ----------------
    ls_req = 1'b1; ls_addr = 32'h600; ls_be = 4'hF; mem_gnt = 1'b1;
    sample();
    check("t6_ls_gnt", {31'h0, ls_gnt}, 32'h1);
    next_cycle();
    clear_inputs();
    sample();
    check("t6_busy_before", {31'h0, busy}, 32'h1);
    next_cycle();
    rstb = 1'b0;
    #1;
    check_all_zero("t6_rst");
    next_cycle();
    rstb = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    sample();
    check("t6_late_rv",    {30'h0, if_rvalid, ls_rvalid}, 32'h0);
    check("t6_late_rdata", ls_rdata, 32'h0);
    check("t6_late_busy",  {31'h0, busy}, 32'h0);
    next_cycle();
    clear_inputs();
    if_req = 1'b1; if_addr = 32'h700; mem_gnt = 1'b1;
    sample();
    check("t6_if_gnt",   {31'h0, if_gnt}, 32'h1);
    check("t6_mem_addr", mem_addr, 32'h700);
    next_cycle();
    if_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h13579BDF;
    sample();
    check("t6_if_rvalid", {31'h0, if_rvalid}, 32'h1);
    check("t6_if_rdata",  if_rdata, 32'h13579BDF);
    next_cycle();
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
